ram_port_arbiter: RTL and testbench

//  Shares the single-port weight/activation RAM (sync write, 1-cycle registered read,

---
 rtl/ram_port_arbiter_pkg.sv | 20 ++
 rtl/ram_port_arbiter_rr_arbiter.sv | 52 +++++
 rtl/ram_port_arbiter.sv | 109 ++++++++++
 tb/tb_ram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ============================================================================
// Package : ram_arb_pkg
// Brief   : Default sizing and shared helpers for the RAM port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int C_DEF_NUM_REQ    = 2;
  localparam int C_DEF_ADDR_WIDTH = 8;
  localparam int C_DEF_DATA_WIDTH = 16;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; owns the priority pointer, one-hot grant out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_pos;

  // Scan from the pointer upward, wrapping, and stop at the first requester.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
      if (!o_any && i_req[w_pos[IW-1:0]]) begin
        o_grant[w_pos[IW-1:0]] = 1'b1;
        o_idx                  = w_pos[IW-1:0];
        o_any                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= IW'(wrap_inc(32'(o_idx), N));
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Shares one single-port RAM among NUM_REQ requesters, round-robin,
//          with read data routed back to its requester two cycles after accept.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = C_DEF_NUM_REQ,
  parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                rd;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  req_t                  w_req [NUM_REQ];
  req_t                  w_sel;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_any;

  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  tag_t                  r_tag1;
  tag_t                  r_tag2;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req[gi].we    = req_we[gi];
    assign w_req[gi].addr  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req[gi].wdata = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;
  assign w_sel     = w_req[w_idx];

  // Address/data hold when idle so the RAM just repeats a harmless read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
    end else begin
      r_ram_we <= w_any & w_sel.we;
      if (w_any) begin
        r_ram_addr  <= w_sel.addr;
        r_ram_wdata <= w_sel.wdata;
      end
      r_tag1.rd <= w_any & ~w_sel.we;
      r_tag1.id <= w_idx;
      r_tag2    <= r_tag1;
    end
  end

  // Stage 2 lines up with the RAM's registered read data.
  always_comb begin
    rsp_valid = '0;
    if (r_tag2.rd) rsp_valid[r_tag2.id] = 1'b1;
  end

  assign rsp_data  = ram_rdata;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module : tb_ram_port_arbiter
// Brief  : Self-checking bench for ram_port_arbiter with a behavioural RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h10) return 16'hBEEF;
    return DW'(i * 40503) ^ 16'h5A5A;
  endfunction

  // RAM: synchronous write, 1-cycle registered read, output held during writes.
  logic [DW-1:0] ram_mem [256];
  initial begin
    ram_rdata <= '0;
    for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
    forever begin
      @(posedge clk);
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: intended memory contents plus expected responses.
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [DW-1:0] m_mem [256];
  rsp_t          exp_q [$];
  int            cyc;
  int            m_ptr;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    exp_q.delete();
    m_ptr   = 0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
  endtask

  // One clock: check registered outputs, drive new requests, check grant, update model.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] we,
                      input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                      output logic [NR-1:0] g);
    logic [NR-1:0] exp_rv;
    logic [NR-1:0] eg;
    logic [DW-1:0] exp_d;
    int gi;
    int j;
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    if (ram_we !== e_we) begin
      errors++; $display("FAIL ram_we cyc %0d: got %b want %b", cyc, ram_we, e_we);
    end
    checks++;
    if (ram_addr !== e_addr) begin
      errors++; $display("FAIL ram_addr cyc %0d: got %h want %h", cyc, ram_addr, e_addr);
    end
    checks++;
    if (ram_wdata !== e_wdata) begin
      errors++; $display("FAIL ram_wdata cyc %0d: got %h want %h", cyc, ram_wdata, e_wdata);
    end
    exp_rv = '0;
    exp_d  = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].id] = 1'b1;
      exp_d = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    checks++;
    if (rsp_valid !== exp_rv) begin
      errors++; $display("FAIL rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, exp_rv);
    end
    if (exp_rv != '0) begin
      checks++;
      if (rsp_data !== exp_d) begin
        errors++; $display("FAIL rsp_data cyc %0d: got %h want %h", cyc, rsp_data, exp_d);
      end
    end
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    eg = '0;
    gi = -1;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (gi < 0 && v[j]) begin
        gi = j;
        eg[j] = 1'b1;
      end
    end
    checks++;
    if (req_ready !== eg) begin
      errors++; $display("FAIL req_ready cyc %0d: got %b want %b", cyc, req_ready, eg);
    end
    g = req_ready;
    if (gi >= 0) begin
      m_ptr   = (gi + 1) % NR;
      e_we    = we[gi];
      e_addr  = a[gi*AW +: AW];
      e_wdata = d[gi*DW +: DW];
      if (we[gi]) m_mem[e_addr] = e_wdata;
      else exp_q.push_back('{id: gi, data: m_mem[e_addr], due: cyc + 2});
    end else begin
      e_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [NR-1:0] g;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_ram got we=%b addr=%h wdata=%h want 0", ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_rsp got rsp_valid=%b req_ready=%b want 0", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
    step(2'b11, 2'b00, {8'h21, 8'h20}, '0, g);
    checks++;
    if (g !== 2'b01) begin
      errors++; $display("FAIL first_grant got %b want 01", g);
    end
    step(2'b10, 2'b00, {8'h21, 8'h20}, '0, g);
    checks++;
    if (g !== 2'b10) begin
      errors++; $display("FAIL second_grant got %b want 10", g);
    end
    repeat (3) step('0, '0, '0, '0, g);
  endtask

  task automatic test_single_reader();
    logic [NR-1:0] g;
    step(2'b01, 2'b00, {8'h00, 8'h10}, '0, g);
    step('0, '0, '0, '0, g);
    step('0, '0, '0, '0, g);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL single_read got %b/%h want 01/beef", rsp_valid, rsp_data);
    end
    repeat (2) step('0, '0, '0, '0, g);
  endtask

  task automatic test_contention();
    logic [NR-1:0] g;
    logic [NR-1:0] prev;
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      step(2'b11, 2'b00, {8'h31, 8'h30}, '0, g);
      checks++;
      if (!(g == 2'b01 || g == 2'b10) || g === prev) begin
        errors++; $display("FAIL contention_alt step %0d got %b prev %b", k, g, prev);
      end
      prev = g;
    end
    repeat (3) step('0, '0, '0, '0, g);
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] g;
    for (int k = 0; k < 5; k++) begin
      step(2'b10, 2'b00, {AW'(8'h40 + k), 8'h00}, '0, g);
      checks++;
      if (g !== 2'b10) begin
        errors++; $display("FAIL single_stream step %0d got %b want 10", k, g);
      end
    end
    repeat (3) step('0, '0, '0, '0, g);
  endtask

  task automatic test_raw();
    logic [NR-1:0] g;
    step(2'b10, 2'b10, {8'h22, 8'h00}, {16'h1234, 16'h0000}, g);
    step(2'b01, 2'b00, {8'h00, 8'h22}, '0, g);
    step('0, '0, '0, '0, g);
    step('0, '0, '0, '0, g);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 16'h1234) begin
      errors++; $display("FAIL raw got %b/%h want 01/1234", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_idle_gap();
    logic [NR-1:0] g;
    for (int k = 0; k < 3; k++) begin
      step('0, '0, '0, '0, g);
      checks++;
      if (ram_we !== 1'b0 || rsp_valid !== '0 || ram_addr !== 8'h22) begin
        errors++; $display("FAIL idle_gap %0d got we=%b rsp=%b addr=%h want 0/00/22", k, ram_we, rsp_valid, ram_addr);
      end
    end
  endtask

  task automatic test_random();
    logic [NR-1:0]    g;
    logic [NR-1:0]    pv;
    logic [NR-1:0]    pwe;
    logic [NR*AW-1:0] pa;
    logic [NR*DW-1:0] pd;
    int               waits [NR];
    pv = '0; pwe = '0; pa = '0; pd = '0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    repeat (300) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 3) != 0) begin
          pv[i]         = 1'b1;
          pwe[i]        = ($urandom_range(0, 2) == 0);
          pa[i*AW +: AW] = AW'($urandom_range(0, 15));
          pd[i*DW +: DW] = DW'($urandom);
        end
      end
      step(pv, pwe, pa, pd, g);
      for (int i = 0; i < NR; i++) begin
        if (pv[i] && !g[i]) waits[i]++;
        else waits[i] = 0;
        checks++;
        if (waits[i] >= NR) begin
          errors++; $display("FAIL fairness req %0d waited %0d want <%0d", i, waits[i], NR);
        end
      end
      pv = pv & ~g;
    end
    repeat (NR) begin
      step(pv, pwe, pa, pd, g);
      pv = pv & ~g;
    end
    repeat (3) step('0, '0, '0, '0, g);
  endtask

  task automatic test_reset_mid_read();
    logic [NR-1:0] g;
    step(2'b01, 2'b00, {8'h00, 8'h05}, '0, g);
    step('0, '0, '0, '0, g);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || rsp_valid !== '0) begin
      errors++; $display("FAIL mid_reset got we=%b addr=%h rsp=%b want 0", ram_we, ram_addr, rsp_valid);
    end
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0, '0, g);
      checks++;
      if (rsp_valid !== '0) begin
        errors++; $display("FAIL dropped_read %0d got %b want 00", k, rsp_valid);
      end
    end
    step(2'b11, 2'b00, {8'h11, 8'h10}, '0, g);
    checks++;
    if (g !== 2'b01) begin
      errors++; $display("FAIL ptr_after_reset got %b want 01", g);
    end
    step('0, '0, '0, '0, g);
    repeat (3) step('0, '0, '0, '0, g);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    cyc = 0;
    model_reset();
    test_reset();
    test_single_reader();
    test_contention();
    test_back_to_back();
    test_raw();
    test_idle_gap();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
